// File: rtl/writeback_arbiter.sv
// Writeback arbiter: one holding slot per source (exe, mem) feeding a single registered regfile write port.
// Grant is combinational from slot state, the write is registered one edge later; mem wins unless exe has starved STARVE_LIMIT cycles.
module writeback_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_i_valid,
  input  logic [4:0]  exe_i_rd,
  input  logic [63:0] exe_i_data,
  input  logic        exe_i_reg_wen,
  output logic        exe_o_ready,
  input  logic        mem_i_valid,
  input  logic [4:0]  mem_i_rd,
  input  logic [63:0] mem_i_data,
  input  logic        mem_i_reg_wen,
  output logic        mem_o_ready,
  output logic [4:0]  write_back_o_rd,
  output logic [63:0] write_back_o_data,
  output logic        write_back_o_reg_wen,
  output logic [31:0] wb_o_commit_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic        exe_full_q, exe_full_d;
  logic [4:0]  exe_rd_q, exe_rd_d;
  logic [63:0] exe_data_q, exe_data_d;
  logic        exe_wen_q, exe_wen_d;
  logic        mem_full_q, mem_full_d;
  logic [4:0]  mem_rd_q, mem_rd_d;
  logic [63:0] mem_data_q, mem_data_d;
  logic        mem_wen_q, mem_wen_d;
  logic [3:0]  starve_q, starve_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [63:0] wb_data_q, wb_data_d;
  logic        wb_wen_q, wb_wen_d;
  logic [31:0] cnt_q, cnt_d;

  logic mem_gnt, exe_gnt;
  logic exe_load, mem_load;

  // Readies are gated by reset so nothing is accepted while the block is held.
  always_comb begin
    mem_gnt     = mem_full_q && !(exe_full_q && (starve_q == LIMIT));
    exe_gnt     = exe_full_q && !mem_gnt;
    exe_o_ready = rst && (!exe_full_q || exe_gnt);
    mem_o_ready = rst && (!mem_full_q || mem_gnt);
    exe_load    = exe_i_valid && exe_o_ready;
    mem_load    = mem_i_valid && mem_o_ready;
  end

  always_comb begin
    exe_full_d = exe_full_q;
    exe_rd_d   = exe_rd_q;
    exe_data_d = exe_data_q;
    exe_wen_d  = exe_wen_q;
    mem_full_d = mem_full_q;
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    mem_wen_d  = mem_wen_q;
    starve_d   = starve_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_wen_d   = 1'b0;

    if (exe_load) begin
      exe_full_d = 1'b1;
      exe_rd_d   = exe_i_rd;
      exe_data_d = exe_i_data;
      exe_wen_d  = exe_i_reg_wen;
    end else if (exe_gnt) begin
      exe_full_d = 1'b0;
    end

    if (mem_load) begin
      mem_full_d = 1'b1;
      mem_rd_d   = mem_i_rd;
      mem_data_d = mem_i_data;
      mem_wen_d  = mem_i_reg_wen;
    end else if (mem_gnt) begin
      mem_full_d = 1'b0;
    end

    if (!exe_full_q || exe_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + 4'd1;
    end

    // Null entries (rd 0 or no write request) still burn their grant cycle.
    if (mem_gnt) begin
      wb_rd_d   = mem_rd_q;
      wb_data_d = mem_data_q;
      wb_wen_d  = mem_wen_q && (mem_rd_q != 5'd0);
    end else if (exe_gnt) begin
      wb_rd_d   = exe_rd_q;
      wb_data_d = exe_data_q;
      wb_wen_d  = exe_wen_q && (exe_rd_q != 5'd0);
    end

    cnt_d = cnt_q + 32'(wb_wen_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_full_q <= 1'b0;
      exe_rd_q   <= 5'd0;
      exe_data_q <= 64'd0;
      exe_wen_q  <= 1'b0;
      mem_full_q <= 1'b0;
      mem_rd_q   <= 5'd0;
      mem_data_q <= 64'd0;
      mem_wen_q  <= 1'b0;
      starve_q   <= 4'd0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 64'd0;
      wb_wen_q   <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      exe_full_q <= exe_full_d;
      exe_rd_q   <= exe_rd_d;
      exe_data_q <= exe_data_d;
      exe_wen_q  <= exe_wen_d;
      mem_full_q <= mem_full_d;
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
      mem_wen_q  <= mem_wen_d;
      starve_q   <= starve_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_wen_q   <= wb_wen_d;
      cnt_q      <= cnt_d;
    end
  end

  assign write_back_o_rd      = wb_rd_q;
  assign write_back_o_data    = wb_data_q;
  assign write_back_o_reg_wen = wb_wen_q;
  assign wb_o_commit_cnt      = cnt_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a queue-based arbitration model.
module tb_writeback_arbiter;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exe_i_valid = 1'b0, exe_i_reg_wen = 1'b0;
  logic [4:0]  exe_i_rd = '0;
  logic [63:0] exe_i_data = '0;
  logic        mem_i_valid = 1'b0, mem_i_reg_wen = 1'b0;
  logic [4:0]  mem_i_rd = '0;
  logic [63:0] mem_i_data = '0;
  logic        exe_o_ready, mem_o_ready;
  logic [4:0]  write_back_o_rd;
  logic [63:0] write_back_o_data;
  logic        write_back_o_reg_wen;
  logic [31:0] wb_o_commit_cnt;

  writeback_arbiter #(.STARVE_LIMIT(L)) dut (
    .clk(clk), .rst(rst),
    .exe_i_valid(exe_i_valid), .exe_i_rd(exe_i_rd), .exe_i_data(exe_i_data),
    .exe_i_reg_wen(exe_i_reg_wen), .exe_o_ready(exe_o_ready),
    .mem_i_valid(mem_i_valid), .mem_i_rd(mem_i_rd), .mem_i_data(mem_i_data),
    .mem_i_reg_wen(mem_i_reg_wen), .mem_o_ready(mem_o_ready),
    .write_back_o_rd(write_back_o_rd), .write_back_o_data(write_back_o_data),
    .write_back_o_reg_wen(write_back_o_reg_wen), .wb_o_commit_cnt(wb_o_commit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        wen;
  } ent_t;

  // Model: each source holds at most one pending entry; grants drain them in arbitration order.
  ent_t        eq[$];
  ent_t        mq[$];
  int          starve = 0;
  logic [4:0]  exp_rd = '0;
  logic [63:0] exp_data = '0;
  logic        exp_wen = 1'b0;
  logic [31:0] exp_cnt = '0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    eq.delete();
    mq.delete();
    starve   = 0;
    exp_rd   = '0;
    exp_data = '0;
    exp_wen  = 1'b0;
    exp_cnt  = '0;
  endtask

  // One clock cycle: check readies before the edge, advance model at the edge, check write port after it.
  task automatic tick();
    ent_t g;
    bit   mg, eg, exe_nonempty;
    logic er, mr;
    #1;
    exe_nonempty = (eq.size() != 0);
    mg = (mq.size() != 0) && !(exe_nonempty && starve == L);
    eg = !mg && exe_nonempty;
    er = rst && (!exe_nonempty || eg);
    mr = rst && (mq.size() == 0 || mg);
    chk("exe_o_ready", 64'(exe_o_ready), 64'(er));
    chk("mem_o_ready", 64'(mem_o_ready), 64'(mr));
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      g = '{rd: '0, data: '0, wen: 1'b0};
      if (mg) g = mq.pop_front();
      else if (eg) g = eq.pop_front();
      if (exe_i_valid && er) eq.push_back('{rd: exe_i_rd, data: exe_i_data, wen: exe_i_reg_wen});
      if (mem_i_valid && mr) mq.push_back('{rd: mem_i_rd, data: mem_i_data, wen: mem_i_reg_wen});
      if (!exe_nonempty || eg) starve = 0;
      else if (starve < L) starve++;
      if (mg || eg) begin
        exp_rd   = g.rd;
        exp_data = g.data;
        exp_wen  = g.wen && (g.rd != 5'd0);
        if (exp_wen) exp_cnt++;
      end else begin
        exp_wen = 1'b0;
      end
    end
    #1;
    chk("wb_rd", 64'(write_back_o_rd), 64'(exp_rd));
    chk("wb_data", write_back_o_data, exp_data);
    chk("wb_wen", 64'(write_back_o_reg_wen), 64'(exp_wen));
    chk("commit_cnt", 64'(wb_o_commit_cnt), 64'(exp_cnt));
  endtask

  task automatic drive_exe(input logic v, input logic [4:0] rd, input logic [63:0] d, input logic w);
    exe_i_valid = v; exe_i_rd = rd; exe_i_data = d; exe_i_reg_wen = w;
  endtask

  task automatic drive_mem(input logic v, input logic [4:0] rd, input logic [63:0] d, input logic w);
    mem_i_valid = v; mem_i_rd = rd; mem_i_data = d; mem_i_reg_wen = w;
  endtask

  logic [31:0] saved_cnt;
  int pe, pm;

  initial begin
    // Reset with both sources offering data.
    drive_exe(1'b1, 5'd0, 64'h11, 1'b1);
    drive_mem(1'b1, 5'd0, 64'h22, 1'b1);
    tick();
    tick();
    chk("rst_ready_exe", 64'(exe_o_ready), 64'd0);
    chk("rst_ready_mem", 64'(mem_o_ready), 64'd0);
    chk("rst_wen", 64'(write_back_o_reg_wen), 64'd0);
    chk("rst_cnt", 64'(wb_o_commit_cnt), 64'd0);
    rst = 1'b1;
    #1;
    chk("rel_ready_exe", 64'(exe_o_ready), 64'd1);
    chk("rel_ready_mem", 64'(mem_o_ready), 64'd1);
    tick();
    chk("rel_no_write", 64'(write_back_o_reg_wen), 64'd0);
    drive_exe(1'b0, 5'd0, 64'd0, 1'b0);
    drive_mem(1'b0, 5'd0, 64'd0, 1'b0);
    repeat (3) tick();

    // Single exe write.
    drive_exe(1'b1, 5'd5, 64'hDEAD, 1'b1);
    tick();
    drive_exe(1'b0, 5'd0, 64'd0, 1'b0);
    tick();
    chk("single_wen", 64'(write_back_o_reg_wen), 64'd1);
    chk("single_rd", 64'(write_back_o_rd), 64'd5);
    chk("single_data", write_back_o_data, 64'hDEAD);
    chk("single_cnt", 64'(wb_o_commit_cnt), 64'd1);
    tick();
    chk("single_pulse", 64'(write_back_o_reg_wen), 64'd0);

    // Simultaneous: mem first, exe stalled for the intervening cycle.
    drive_exe(1'b1, 5'd3, 64'h333, 1'b1);
    drive_mem(1'b1, 5'd4, 64'h444, 1'b1);
    tick();
    drive_exe(1'b0, 5'd0, 64'd0, 1'b0);
    drive_mem(1'b0, 5'd0, 64'd0, 1'b0);
    chk("sim_exe_stall", 64'(exe_o_ready), 64'd0);
    tick();
    chk("sim_first_rd", 64'(write_back_o_rd), 64'd4);
    tick();
    chk("sim_second_rd", 64'(write_back_o_rd), 64'd3);
    chk("sim_cnt", 64'(wb_o_commit_cnt), 64'd3);
    tick();

    // Starvation: mem streams, one exe entry waits exactly L lost cycles.
    drive_exe(1'b1, 5'd20, 64'h2020, 1'b1);
    drive_mem(1'b1, 5'd11, 64'h1100, 1'b1);
    tick();
    drive_exe(1'b0, 5'd0, 64'd0, 1'b0);
    for (int k = 0; k < L; k++) begin
      mem_i_data = 64'h1101 + 64'(k);
      tick();
      chk("starve_mem_rd", 64'(write_back_o_rd), 64'd11);
    end
    tick();
    chk("starve_exe_rd", 64'(write_back_o_rd), 64'd20);
    tick();
    chk("starve_resume_rd", 64'(write_back_o_rd), 64'd11);
    drive_mem(1'b0, 5'd0, 64'd0, 1'b0);
    repeat (3) tick();

    // Null writes consume grants without writing.
    saved_cnt = wb_o_commit_cnt;
    drive_exe(1'b1, 5'd0, 64'hAAAA, 1'b1);
    tick();
    drive_exe(1'b1, 5'd7, 64'hBBBB, 1'b0);
    tick();
    chk("null_rd0_wen", 64'(write_back_o_reg_wen), 64'd0);
    drive_exe(1'b0, 5'd0, 64'd0, 1'b0);
    tick();
    chk("null_wen0_wen", 64'(write_back_o_reg_wen), 64'd0);
    chk("null_wen0_rd", 64'(write_back_o_rd), 64'd7);
    chk("null_cnt", 64'(wb_o_commit_cnt), 64'(saved_cnt));
    tick();

    // Reset mid-operation with both slots full; held entries must never appear.
    drive_exe(1'b1, 5'd9, 64'hBAD0, 1'b1);
    drive_mem(1'b1, 5'd10, 64'hBAD1, 1'b1);
    tick();
    drive_exe(1'b0, 5'd0, 64'd0, 1'b0);
    drive_mem(1'b0, 5'd0, 64'd0, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_cnt", 64'(wb_o_commit_cnt), 64'd0);
    chk("mid_rst_ready", 64'(exe_o_ready), 64'd0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_rst_no_write", 64'(write_back_o_reg_wen), 64'd0);
    end

    // Randomized traffic with varying source loads and one reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 0) begin
        pe = $urandom_range(10, 100);
        pm = $urandom_range(10, 100);
      end
      drive_exe($urandom_range(0, 99) < pe, 5'($urandom_range(0, 7)),
                {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      drive_mem($urandom_range(0, 99) < pm, 5'($urandom_range(0, 7)),
                {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      if (i == 700) rst = 1'b0;
      if (i == 703) rst = 1'b1;
      tick();
    end
    drive_exe(1'b0, 5'd0, 64'd0, 1'b0);
    drive_mem(1'b0, 5'd0, 64'd0, 1'b0);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
